fb_write_arbiter: RTL and testbench
===================================

# fb_write_arbiter

Shares the single frame-buffer RAM write port between two requesters: port A (UART command path, line/pixel writes from `control_module`) and port B (debug/test-pattern writer). A three-state FSM grants one requester at a time with round-robin fairness. Each grant covers a burst, and a burst is cut at a fixed cap so neither requester can starve the other. The block sits between the requesters and the RAM's `ram_address`/`ram_data_out`/`ram_write_enable`/`ram_clk_enable` inputs.

## Interface
Parameters:
- `ADDR_WIDTH`, 12, RAM address width
- `DATA_WIDTH`, 8, RAM data width
- `MAX_BURST`, 64, maximum accepted writes per grant; legal range 1..2^`BURST_WIDTH`-1
- `BURST_WIDTH`, 7, width of the burst counter

Ports:
- `clk_in`  in  1  single clock; all logic on its rising edge
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted)
- `req_a` / `req_b`  in  1  write request; held high with valid addr/data
- `addr_a` / `addr_b`  in  ADDR_WIDTH  write address
- `data_a` / `data_b`  in  DATA_WIDTH  write data
- `last_a` / `last_b`  in  1  marks the final write of the burst; qualified by accept
- `gnt_a` / `gnt_b`  out  1  registered grant
- `ram_address`  out  ADDR_WIDTH  registered RAM address
- `ram_data_out`  out  DATA_WIDTH  registered RAM write data
- `ram_write_enable`  out  1  registered one-cycle write strobe
- `ram_clk_enable`  out  1  RAM clock enable
- `contention_count`  out  8  present only with the stats macro
- `cut_count`  out  8  present only with the stats macro

## Operation
- FSM states: `IDLE`, `GRANT_A`, `GRANT_B`. `gnt_a` = (state==`GRANT_A`). `gnt_b` = (state==`GRANT_B`).
- Accept on port x: `gnt_x & req_x` at a rising edge. One write per accept. At that edge the arbiter registers `addr_x`/`data_x` into `ram_address`/`ram_data_out` and sets `ram_write_enable`=1 for the following cycle.
- Transitions out of `IDLE`:
  - only `req_a` high -> `GRANT_A`
  - only `req_b` high -> `GRANT_B`
  - both high -> the port that is not `last_served`
  - neither high -> stay in `IDLE`
- `GRANT_x` -> `IDLE` when any of the following holds:
  - accept with `last_x`=1
  - `req_x`=0 (no write this cycle)
  - the accept that makes the burst counter equal `MAX_BURST` (forced cut)
- On every exit from `GRANT_x`: `last_served` <= x and the burst counter is cleared.
- `IDLE` always lasts at least one cycle, so grants never switch directly A<->B.
- The burst counter increments only on an accept and never wraps. A cut occurs before it can overflow.
- `ram_clk_enable` = `ram_write_enable` | `gnt_a` | `gnt_b`.
- Address and data are passed through unmodified. No address range check.

## Timing
- Reset values: state=`IDLE`; `gnt_a`=`gnt_b`=0; `ram_write_enable`=0; `ram_clk_enable`=0; `ram_address`=0; `ram_data_out`=0; `last_served`=B (so A wins the first tie); burst counter=0; stats counters=0.
- From `req_x` rising (sampled at edge n) in `IDLE`: `gnt_x` high after edge n, first accept at edge n+1, `ram_write_enable` high after edge n+1.
- Sustained burst: one write per cycle with no bubbles while `req_x` stays high.
- Handover after a burst ends at edge m: `IDLE` during cycle m+1, the other port is granted after edge m+1, and its first write strobe follows after edge m+2.
- Simultaneous `req_a` and `req_b` rising in `IDLE` resolve by the round-robin pointer only. There is no fixed priority.
- Reset asserted mid-burst: all outputs clear asynchronously. The registered write in flight is dropped. After release, arbitration restarts from `IDLE`.
- A requester must hold addr/data stable while `req_x`=1 and `gnt_x`=0.

## Configuration
- `FB_WRITE_ARB_STATS_EN`: when defined, the block adds two 8-bit saturating counters, both cleared by reset:
  - `contention_count` increments on each `IDLE` edge with both requests high.
  - `cut_count` increments on each forced burst cut.
- When undefined, both ports and all their logic are absent. Arbitration behaviour is identical in both builds.

## Structure
- Package `fb_arb_pkg`: state encoding (`IDLE`/`GRANT_A`/`GRANT_B`), requester-id constants (`REQ_A`=0, `REQ_B`=1) and the default `MAX_BURST`.
- One sub-module: `sat_counter`, a generic width-parameterised saturating up-counter with an increment enable. It is instantiated twice, only under `FB_WRITE_ARB_STATS_EN`.

## Test plan
- Reset check, then `req_a`=1 only with 3 writes (addr 0x010..0x012, data 0xA0..0xA2, `last_a` on the third) -> strobes on 3 consecutive cycles with matching addr/data; `gnt_a` falls after the third accept.
- `req_a` and `req_b` rise on the same edge after reset -> A is granted first. After A's `last_a`, one `IDLE` cycle, then B is granted.
- `MAX_BURST`=4; A requests 10 writes with no `last_a` while B is requesting -> A is cut after exactly 4 writes, B is served, then A resumes at its 5th address. `cut_count`=1 if stats are enabled.
- `req_b` drops mid-burst after 2 writes -> no strobe that cycle, FSM returns to `IDLE`, `gnt_b` falls.
- `reset` pulled low during the 2nd write of a burst -> `ram_write_enable`, `gnt_a` and `ram_address` read 0 immediately. After release, the first strobe appears 2 cycles after a fresh request.
- Stats build: hold both requests high through 300 contended `IDLE` cycles -> `contention_count` saturates at 255.

Source files
------------

// File: rtl/fb_arb_pkg.sv
// Shared definitions for the frame-buffer write arbiter: FSM state
// encoding, requester identifiers and the default burst cap.
package fb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } arb_state_e;

  // Requester identifiers, used for the round-robin pointer.
  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  localparam int DEFAULT_MAX_BURST = 64;

endpackage

// File: rtl/sat_counter.sv
// Generic saturating up-counter: counts enabled cycles and holds at all-ones.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: step only when enabled and not yet saturated.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register, cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/fb_write_arbiter.sv
// Frame-buffer write-port arbiter between port A (command path) and port B
// (debug/test-pattern writer). Round-robin grants with a burst cap.
// Optional statistics counters are built when FB_WRITE_ARB_STATS_EN is defined.
//
// Handshake: req_x acts as valid and gnt_x as ready. A write is accepted on
// every rising edge where gnt_x & req_x are both high; the requester must
// hold addr_x/data_x/last_x stable while req_x=1 and gnt_x=0, and may change
// them to the next beat after each accepting edge. last_x is only meaningful
// on an accepting edge.
module fb_write_arbiter
  import fb_arb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 8,
  parameter int MAX_BURST   = DEFAULT_MAX_BURST,
  parameter int BURST_WIDTH = 7
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic                  req_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] data_a,
  input  logic                  last_a,
  input  logic                  req_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] data_b,
  input  logic                  last_b,
  output logic                  gnt_a,
  output logic                  gnt_b,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data_out,
  output logic                  ram_write_enable,
  output logic                  ram_clk_enable,
  output logic [1:0]            dbg_state
`ifdef FB_WRITE_ARB_STATS_EN
  ,
  output logic [7:0]            contention_count,
  output logic [7:0]            cut_count
`endif
);

  arb_state_e             state_q, state_d;
  logic                   last_served_q, last_served_d;
  logic [BURST_WIDTH-1:0] burst_q, burst_d;
  logic                   gnt_a_q, gnt_a_d;
  logic                   gnt_b_q, gnt_b_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic                   we_q, we_d;

  logic [BURST_WIDTH-1:0] burst_inc;
  logic                   at_cap;

  // The accept being processed brings the counter to the cap.
  assign burst_inc = burst_q + 1'b1;
  assign at_cap    = (burst_inc == BURST_WIDTH'(MAX_BURST));

  // Next-state, round-robin pick and write capture for the arbiter FSM.
  always_comb begin
    state_d       = state_q;
    last_served_d = last_served_q;
    burst_d       = burst_q;
    we_d          = 1'b0;
    addr_d        = addr_q;
    data_d        = data_q;
    case (state_q)
      IDLE: begin
        // A tie goes to whichever port was not served last.
        if (req_a && req_b) begin
          state_d = (last_served_q == REQ_A) ? GRANT_B : GRANT_A;
        end else if (req_a) begin
          state_d = GRANT_A;
        end else if (req_b) begin
          state_d = GRANT_B;
        end
      end
      GRANT_A: begin
        if (!req_a) begin
          state_d       = IDLE;
          last_served_d = REQ_A;
          burst_d       = '0;
        end else begin
          we_d    = 1'b1;
          addr_d  = addr_a;
          data_d  = data_a;
          burst_d = burst_inc;
          if (last_a || at_cap) begin
            state_d       = IDLE;
            last_served_d = REQ_A;
            burst_d       = '0;
          end
        end
      end
      GRANT_B: begin
        if (!req_b) begin
          state_d       = IDLE;
          last_served_d = REQ_B;
          burst_d       = '0;
        end else begin
          we_d    = 1'b1;
          addr_d  = addr_b;
          data_d  = data_b;
          burst_d = burst_inc;
          if (last_b || at_cap) begin
            state_d       = IDLE;
            last_served_d = REQ_B;
            burst_d       = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Grants are registered copies of the next state.
    gnt_a_d = (state_d == GRANT_A);
    gnt_b_d = (state_d == GRANT_B);
  end

  // FSM state and all registered outputs; asynchronous reset drops any write in flight.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      last_served_q <= REQ_B;
      burst_q       <= '0;
      gnt_a_q       <= 1'b0;
      gnt_b_q       <= 1'b0;
      addr_q        <= '0;
      data_q        <= '0;
      we_q          <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_served_q <= last_served_d;
      burst_q       <= burst_d;
      gnt_a_q       <= gnt_a_d;
      gnt_b_q       <= gnt_b_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      we_q          <= we_d;
    end
  end

  assign gnt_a            = gnt_a_q;
  assign gnt_b            = gnt_b_q;
  assign ram_address      = addr_q;
  assign ram_data_out     = data_q;
  assign ram_write_enable = we_q;
  assign ram_clk_enable   = we_q | gnt_a_q | gnt_b_q;
  assign dbg_state        = state_q;

`ifdef FB_WRITE_ARB_STATS_EN
  logic contention_event;
  logic cut_event;

  // Contention: both ports asking while idle. Cut: the cap ended a burst
  // that the requester had not marked as finished.
  assign contention_event = (state_q == IDLE) & req_a & req_b;
  assign cut_event = ((gnt_a_q & req_a & ~last_a) | (gnt_b_q & req_b & ~last_b)) & at_cap;

  sat_counter #(.WIDTH(8)) u_contention_cnt (
    .clk   (clk_in),
    .rst_n (reset),
    .inc   (contention_event),
    .count (contention_count)
  );

  sat_counter #(.WIDTH(8)) u_cut_cnt (
    .clk   (clk_in),
    .rst_n (reset),
    .inc   (cut_event),
    .count (cut_count)
  );
`endif

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter (built with MAX_BURST=4). Statistics
// checks are compiled in only when FB_WRITE_ARB_STATS_EN is defined.
module tb_fb_write_arbiter;

  localparam int AW = 12;
  localparam int DW = 8;
  localparam int W  = AW + DW;

  // ---------------- clock / reset ----------------
  logic clk_in = 1'b0;
  logic reset  = 1'b0;
  always #5 clk_in = ~clk_in;

  logic          req_a, last_a, req_b, last_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] data_a, data_b;
  logic          gnt_a, gnt_b, ram_write_enable, ram_clk_enable;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data_out;
  logic [1:0]    dbg_state;
`ifdef FB_WRITE_ARB_STATS_EN
  logic [7:0]    contention_count, cut_count;
`endif

  fb_write_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .MAX_BURST  (4),
    .BURST_WIDTH(7)
  ) dut (
    .clk_in          (clk_in),
    .reset           (reset),
    .req_a           (req_a),
    .addr_a          (addr_a),
    .data_a          (data_a),
    .last_a          (last_a),
    .req_b           (req_b),
    .addr_b          (addr_b),
    .data_b          (data_b),
    .last_b          (last_b),
    .gnt_a           (gnt_a),
    .gnt_b           (gnt_b),
    .ram_address     (ram_address),
    .ram_data_out    (ram_data_out),
    .ram_write_enable(ram_write_enable),
    .ram_clk_enable  (ram_clk_enable),
    .dbg_state       (dbg_state)
`ifdef FB_WRITE_ARB_STATS_EN
    ,
    .contention_count(contention_count),
    .cut_count       (cut_count)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- write scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic         sb_en = 1'b1;

  always @(negedge clk_in) begin
    if (sb_en && reset && ram_write_enable) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL wr_sb_unexpected: got 0x%0h/0x%0h expected no write", ram_address, ram_data_out);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("wr_sb", {ram_address, ram_data_out}, e);
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic          rst;
    logic          ra, la;
    logic [AW-1:0] aa;
    logic [DW-1:0] da;
    logic          rb, lb;
    logic [AW-1:0] ab;
    logic [DW-1:0] db;
    logic          ega, egb, ewe;
    logic [AW-1:0] eaddr;
    logic [DW-1:0] edata;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst,
                              input logic ra, input logic la, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                              input logic rb, input logic lb, input logic [AW-1:0] ab, input logic [DW-1:0] db,
                              input logic ega, input logic egb, input logic ewe,
                              input logic [AW-1:0] eaddr, input logic [DW-1:0] edata);
    vec_t v;
    v.rst = rst; v.ra = ra; v.la = la; v.aa = aa; v.da = da;
    v.rb = rb; v.lb = lb; v.ab = ab; v.db = db;
    v.ega = ega; v.egb = egb; v.ewe = ewe; v.eaddr = eaddr; v.edata = edata;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    req_a = 0; last_a = 0; addr_a = '0; data_a = '0;
    req_b = 0; last_b = 0; addr_b = '0; data_b = '0;
  endtask

  // Called at a negedge; returns at a negedge with reset released.
  task automatic do_reset();
    reset = 1'b0;
    drive_idle();
    repeat (2) @(negedge clk_in);
    reset = 1'b1;
  endtask

  task automatic check_outputs(input string tag, input logic ega, input logic egb, input logic ewe,
                               input logic [AW-1:0] eaddr, input logic [DW-1:0] edata);
    logic [1:0] est;
    est = ega ? 2'd1 : (egb ? 2'd2 : 2'd0);
    check({tag, "_gnt_a"}, gnt_a, ega);
    check({tag, "_gnt_b"}, gnt_b, egb);
    check({tag, "_we"}, ram_write_enable, ewe);
    check({tag, "_addr"}, ram_address, eaddr);
    check({tag, "_data"}, ram_data_out, edata);
    check({tag, "_clk_en"}, ram_clk_enable, ewe | ega | egb);
    check({tag, "_state"}, dbg_state, est);
  endtask

  // Drive one vector at a negedge, let one rising edge pass, compare at the next negedge.
  task automatic apply(input int idx, input vec_t v);
    if (v.rst) do_reset();
    req_a = v.ra; last_a = v.la; addr_a = v.aa; data_a = v.da;
    req_b = v.rb; last_b = v.lb; addr_b = v.ab; data_b = v.db;
    if (v.ewe) exp_q.push_back({v.eaddr, v.edata});
    @(posedge clk_in);
    @(negedge clk_in);
    check_outputs($sformatf("v%0d", idx), v.ega, v.egb, v.ewe, v.eaddr, v.edata);
  endtask

  initial begin
    drive_idle();

    // Reset values while reset is asserted.
    @(negedge clk_in);
    check_outputs("reset", 1'b0, 1'b0, 1'b0, '0, '0);
`ifdef FB_WRITE_ARB_STATS_EN
    check("reset_contention", contention_count, 0);
    check("reset_cut", cut_count, 0);
`endif

    // A alone: three writes, last on the third.
    tbl.push_back(mk(1, 1,0,12'h010,8'hA0, 0,0,12'h000,8'h00, 1,0,0,12'h000,8'h00));
    tbl.push_back(mk(0, 1,0,12'h010,8'hA0, 0,0,12'h000,8'h00, 1,0,1,12'h010,8'hA0));
    tbl.push_back(mk(0, 1,0,12'h011,8'hA1, 0,0,12'h000,8'h00, 1,0,1,12'h011,8'hA1));
    tbl.push_back(mk(0, 1,1,12'h012,8'hA2, 0,0,12'h000,8'h00, 0,0,1,12'h012,8'hA2));
    tbl.push_back(mk(0, 0,0,12'h000,8'h00, 0,0,12'h000,8'h00, 0,0,0,12'h012,8'hA2));
    // Both rise after reset: A first, one idle cycle, then B.
    tbl.push_back(mk(1, 1,0,12'h020,8'hB0, 1,0,12'h100,8'hC0, 1,0,0,12'h000,8'h00));
    tbl.push_back(mk(0, 1,1,12'h020,8'hB0, 1,0,12'h100,8'hC0, 0,0,1,12'h020,8'hB0));
    tbl.push_back(mk(0, 0,0,12'h000,8'h00, 1,0,12'h100,8'hC0, 0,1,0,12'h020,8'hB0));
    tbl.push_back(mk(0, 0,0,12'h000,8'h00, 1,1,12'h100,8'hC0, 0,0,1,12'h100,8'hC0));
    tbl.push_back(mk(0, 0,0,12'h000,8'h00, 0,0,12'h000,8'h00, 0,0,0,12'h100,8'hC0));
    // A long burst cut at 4 while B waits, B served, A resumes at its 5th address.
    tbl.push_back(mk(0, 1,0,12'h200,8'h40, 1,0,12'h300,8'h50, 1,0,0,12'h100,8'hC0));
    tbl.push_back(mk(0, 1,0,12'h200,8'h40, 1,0,12'h300,8'h50, 1,0,1,12'h200,8'h40));
    tbl.push_back(mk(0, 1,0,12'h201,8'h41, 1,0,12'h300,8'h50, 1,0,1,12'h201,8'h41));
    tbl.push_back(mk(0, 1,0,12'h202,8'h42, 1,0,12'h300,8'h50, 1,0,1,12'h202,8'h42));
    tbl.push_back(mk(0, 1,0,12'h203,8'h43, 1,0,12'h300,8'h50, 0,0,1,12'h203,8'h43));
    tbl.push_back(mk(0, 1,0,12'h204,8'h44, 1,0,12'h300,8'h50, 0,1,0,12'h203,8'h43));
    tbl.push_back(mk(0, 1,0,12'h204,8'h44, 1,0,12'h300,8'h50, 0,1,1,12'h300,8'h50));
    tbl.push_back(mk(0, 1,0,12'h204,8'h44, 1,1,12'h301,8'h51, 0,0,1,12'h301,8'h51));
    tbl.push_back(mk(0, 1,0,12'h204,8'h44, 0,0,12'h000,8'h00, 1,0,0,12'h301,8'h51));
    tbl.push_back(mk(0, 1,0,12'h204,8'h44, 0,0,12'h000,8'h00, 1,0,1,12'h204,8'h44));
    tbl.push_back(mk(0, 1,1,12'h205,8'h45, 0,0,12'h000,8'h00, 0,0,1,12'h205,8'h45));
    tbl.push_back(mk(0, 0,0,12'h000,8'h00, 0,0,12'h000,8'h00, 0,0,0,12'h205,8'h45));
    // Tie with A served last: B wins this time.
    tbl.push_back(mk(0, 1,0,12'h500,8'h80, 1,0,12'h600,8'h70, 0,1,0,12'h205,8'h45));
    tbl.push_back(mk(0, 1,0,12'h500,8'h80, 1,1,12'h600,8'h70, 0,0,1,12'h600,8'h70));
    tbl.push_back(mk(0, 1,0,12'h500,8'h80, 0,0,12'h000,8'h00, 1,0,0,12'h600,8'h70));
    tbl.push_back(mk(0, 1,1,12'h500,8'h80, 0,0,12'h000,8'h00, 0,0,1,12'h500,8'h80));
    tbl.push_back(mk(0, 0,0,12'h000,8'h00, 0,0,12'h000,8'h00, 0,0,0,12'h500,8'h80));
    // B drops its request after two writes: no strobe, grant falls.
    tbl.push_back(mk(0, 0,0,12'h000,8'h00, 1,0,12'h400,8'h60, 0,1,0,12'h500,8'h80));
    tbl.push_back(mk(0, 0,0,12'h000,8'h00, 1,0,12'h400,8'h60, 0,1,1,12'h400,8'h60));
    tbl.push_back(mk(0, 0,0,12'h000,8'h00, 1,0,12'h401,8'h61, 0,1,1,12'h401,8'h61));
    tbl.push_back(mk(0, 0,0,12'h000,8'h00, 0,0,12'h000,8'h00, 0,0,0,12'h401,8'h61));
    tbl.push_back(mk(0, 0,0,12'h000,8'h00, 0,0,12'h000,8'h00, 0,0,0,12'h401,8'h61));

    foreach (tbl[i]) apply(i, tbl[i]);

`ifdef FB_WRITE_ARB_STATS_EN
    // Contended idle edges since the last reset: 4; one forced cut.
    check("stats_contention", contention_count, 4);
    check("stats_cut", cut_count, 1);
`endif

    // Reset during the second write of a burst.
    req_a = 1; addr_a = 12'h700; data_a = 8'h90; last_a = 0;
    @(posedge clk_in); @(negedge clk_in);
    check_outputs("rm_grant", 1'b1, 1'b0, 1'b0, 12'h401, 8'h61);
    exp_q.push_back({12'h700, 8'h90});
    @(posedge clk_in); @(negedge clk_in);
    check_outputs("rm_w1", 1'b1, 1'b0, 1'b1, 12'h700, 8'h90);
    addr_a = 12'h701; data_a = 8'h91;
    exp_q.push_back({12'h701, 8'h91});
    @(posedge clk_in); @(negedge clk_in);
    check_outputs("rm_w2", 1'b1, 1'b0, 1'b1, 12'h701, 8'h91);
    #2;
    reset = 1'b0;
    #1;
    check_outputs("rm_async", 1'b0, 1'b0, 1'b0, '0, '0);
    drive_idle();
    repeat (2) @(negedge clk_in);
    reset = 1'b1;
    @(posedge clk_in); @(negedge clk_in);
    check_outputs("rm_idle", 1'b0, 1'b0, 1'b0, '0, '0);
    req_a = 1; addr_a = 12'h710; data_a = 8'h92;
    @(posedge clk_in); @(negedge clk_in);
    check_outputs("rm_regrant", 1'b1, 1'b0, 1'b0, '0, '0);
    last_a = 1;
    exp_q.push_back({12'h710, 8'h92});
    @(posedge clk_in); @(negedge clk_in);
    check_outputs("rm_first", 1'b0, 1'b0, 1'b1, 12'h710, 8'h92);
    drive_idle();
    @(posedge clk_in); @(negedge clk_in);
    check_outputs("rm_end", 1'b0, 1'b0, 1'b0, 12'h710, 8'h92);

    check("wr_sb_drain", exp_q.size(), 0);

`ifdef FB_WRITE_ARB_STATS_EN
    // Saturation: both ports request continuously, every burst is cut.
    sb_en = 1'b0;
    do_reset();
    req_a = 1; addr_a = 12'h800; data_a = 8'h11;
    req_b = 1; addr_b = 12'h900; data_b = 8'h22;
    for (int i = 0; i < 4000 && contention_count != 8'd255; i++) @(negedge clk_in);
    check("sat_contention", contention_count, 255);
    repeat (60) @(negedge clk_in);
    check("sat_contention_hold", contention_count, 255);
    check("sat_cut", cut_count, 255);
    drive_idle();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
